// File: rtl/fp_mult_pkg.sv
// Shared types and constants for the single-precision FP multiplier datapath.
// Consumed by mant_mult_seq and the downstream normalisation stage.
package fp_mult_pkg;

   localparam int MANT_W = 24;
   localparam int PROD_W = 2 * MANT_W;
   localparam int CNT_W  = 5;
   localparam int BIAS   = 127;

   typedef enum logic [1:0] {IDLE, CALC, DONE} mult_state_t;

   typedef logic [PROD_W-1:0] prod_t;

endpackage

// File: rtl/mant_mult_seq.sv
// Radix-2 shift-add significand multiplier, one add/shift per cycle, start/done handshake.
// Optional MANT_MULT_EARLY_TERM_EN: finish early once the remaining multiplier bits are zero.
//
// state | meaning
// IDLE  | waiting for start; ready=1, p holds last product
// CALC  | one conditional add + right shift per cycle
// DONE  | done pulse, p valid; start here chains the next operation
module mant_mult_seq
   import fp_mult_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [MANT_W-1:0] a,
   input  logic [MANT_W-1:0] b,
   input  logic              sa,
   input  logic              sb,
   output logic              ready,
   output logic              done,
   output prod_t             p,
   output logic              sign_out
);

   localparam int R_W = PROD_W + 1;

   mult_state_t       state;
   logic [MANT_W-1:0] a_reg;
   logic [R_W-1:0]    r_reg;
   logic [R_W-1:0]    r_step;
   logic [R_W-1:0]    r_next;
   logic [CNT_W-1:0]  count;
   logic [MANT_W:0]   sum;
   logic              last;

`ifdef MANT_MULT_EARLY_TERM_EN
   logic [MANT_W-1:0] lo_mask;
   logic              rest_zero;
   logic [5:0]        sh_amt;
`endif

   // {carry,hi} is the accumulator; lo holds the unconsumed multiplier bits
   always_comb begin
      sum    = r_reg[0] ? (r_reg[PROD_W:MANT_W] + {1'b0, a_reg}) : r_reg[PROD_W:MANT_W];
      r_step = {1'b0, sum, r_reg[MANT_W-1:1]};
      last   = (count == CNT_W'(MANT_W - 1));
      r_next = r_step;
`ifdef MANT_MULT_EARLY_TERM_EN
      lo_mask   = {MANT_W{1'b1}} >> count;
      rest_zero = ((r_reg[MANT_W-1:0] & lo_mask) == '0);
      sh_amt    = 6'(MANT_W) - {1'b0, count};
      if (rest_zero) begin
         r_next = r_reg >> sh_amt;
         last   = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         a_reg    <= '0;
         r_reg    <= '0;
         count    <= '0;
         p        <= '0;
         sign_out <= 1'b0;
         done     <= 1'b0;
         ready    <= 1'b1;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  a_reg    <= a;
                  r_reg    <= {1'b0, {MANT_W{1'b0}}, b};
                  count    <= '0;
                  sign_out <= sa ^ sb;
                  ready    <= 1'b0;
                  state    <= CALC;
               end else begin
                  state <= IDLE;
               end
            end
            CALC: begin
               r_reg <= r_next;
               count <= count + 1'b1;
               if (last) begin
                  p     <= r_next[PROD_W-1:0];
                  done  <= 1'b1;
                  ready <= 1'b1;
                  state <= DONE;
               end
            end
            default: begin
               state <= IDLE;
               ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mant_mult_seq.sv
// Directed-vector bench for mant_mult_seq: latency, product, sign and handshake checks.
// Expected latency follows MANT_MULT_EARLY_TERM_EN when the bench is built with it.
module tb_mant_mult_seq;
   import fp_mult_pkg::*;

   logic              clk;
   logic              rst_n;
   logic              start;
   logic [MANT_W-1:0] a;
   logic [MANT_W-1:0] b;
   logic              sa;
   logic              sb;
   logic              ready;
   logic              done;
   prod_t             p;
   logic              sign_out;

   int nchecks = 0;
   int nerrs   = 0;

   mant_mult_seq dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .a        (a),
      .b        (b),
      .sa       (sa),
      .sb       (sb),
      .ready    (ready),
      .done     (done),
      .p        (p),
      .sign_out (sign_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [MANT_W-1:0] a;
      logic [MANT_W-1:0] b;
      logic              sa;
      logic              sb;
      prod_t             exp_p;
      logic              exp_sign;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      nchecks++;
      if (act !== exp) begin
         nerrs++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // number of clock edges after acceptance until done is visible
   function automatic int exp_edges(input logic [MANT_W-1:0] bv);
`ifdef MANT_MULT_EARLY_TERM_EN
      if (bv == '0) return 1;
      for (int i = MANT_W - 1; i >= 0; i--)
         if (bv[i]) return (i + 2 > MANT_W) ? MANT_W : i + 2;
      return MANT_W;
`else
      return MANT_W;
`endif
   endfunction

   task automatic start_op(input logic [MANT_W-1:0] av, input logic [MANT_W-1:0] bv,
                           input logic sav, input logic sbv);
      a = av; b = bv; sa = sav; sb = sbv; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input prod_t hold_p, output int n, output bit ready_bad,
                            output bit p_bad);
      n = 0; ready_bad = 1'b0; p_bad = 1'b0;
      do begin
         @(posedge clk); #1;
         n++;
         if (!done) begin
            if (ready !== 1'b0) ready_bad = 1'b1;
            if (p !== hold_p) p_bad = 1'b1;
         end
      end while (!done && n < 40);
   endtask

   vec_t  vecs[$];
   prod_t prev_p;
   int    n;
   int    n2;
   bit    rb;
   bit    pb;

   initial begin
      rst_n = 1'b0; start = 1'b0; a = '0; b = '0; sa = 1'b0; sb = 1'b0;
      prev_p = '0;

      vecs.push_back('{24'h800000, 24'h800000, 1'b0, 1'b1, 48'h4000_0000_0000, 1'b1});
      vecs.push_back('{24'hFFFFFF, 24'hFFFFFF, 1'b1, 1'b1, 48'hFFFF_FE00_0001, 1'b0});
      vecs.push_back('{24'hC00000, 24'hC00000, 1'b1, 1'b0, 48'h9000_0000_0000, 1'b1});
      vecs.push_back('{24'h800000, 24'h000003, 1'b0, 1'b0, 48'h0000_0180_0000, 1'b0});
      vecs.push_back('{24'h123456, 24'h000000, 1'b1, 1'b0, 48'h0000_0000_0000, 1'b1});
      vecs.push_back('{24'h000000, 24'hFFFFFF, 1'b0, 1'b1, 48'h0000_0000_0000, 1'b1});
      vecs.push_back('{24'h000001, 24'h000001, 1'b0, 1'b0, 48'h0000_0000_0001, 1'b0});
      vecs.push_back('{24'h800001, 24'h000002, 1'b1, 1'b1, 48'h0000_0100_0002, 1'b0});
      vecs.push_back('{24'hA00000, 24'h800000, 1'b0, 1'b0, 48'h5000_0000_0000, 1'b0});

      #23;
      check("rst_p", 64'(p), 64'h0);
      check("rst_done", 64'(done), 64'h0);
      check("rst_ready", 64'(ready), 64'h1);
      check("rst_sign", 64'(sign_out), 64'h0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      foreach (vecs[i]) begin
         start_op(vecs[i].a, vecs[i].b, vecs[i].sa, vecs[i].sb);
         check($sformatf("v%0d_ready_calc", i), 64'(ready), 64'h0);
         wait_done(prev_p, n, rb, pb);
         check($sformatf("v%0d_latency", i), 64'(n), 64'(exp_edges(vecs[i].b)));
         check($sformatf("v%0d_done", i), 64'(done), 64'h1);
         check($sformatf("v%0d_p", i), 64'(p), 64'(vecs[i].exp_p));
         check($sformatf("v%0d_sign", i), 64'(sign_out), 64'(vecs[i].exp_sign));
         check($sformatf("v%0d_ready_done", i), 64'(ready), 64'h1);
         check($sformatf("v%0d_ready_low_all", i), 64'(rb), 64'h0);
         check($sformatf("v%0d_p_held", i), 64'(pb), 64'h0);
         @(posedge clk); #1;
         check($sformatf("v%0d_done_width", i), 64'(done), 64'h0);
         check($sformatf("v%0d_p_idle", i), 64'(p), 64'(vecs[i].exp_p));
         prev_p = vecs[i].exp_p;
      end

      // back-to-back: start in the DONE cycle
      start_op(24'h800000, 24'h800000, 1'b0, 1'b0);
      wait_done(prev_p, n, rb, pb);
      check("b2b_first_p", 64'(p), 64'h4000_0000_0000);
      prev_p = 48'h4000_0000_0000;
      start_op(24'hC00000, 24'hC00000, 1'b1, 1'b0);
      check("b2b_accept_ready", 64'(ready), 64'h0);
      check("b2b_accept_done", 64'(done), 64'h0);
      wait_done(prev_p, n, rb, pb);
      check("b2b_latency", 64'(n), 64'(exp_edges(24'hC00000)));
      check("b2b_p", 64'(p), 64'h9000_0000_0000);
      check("b2b_sign", 64'(sign_out), 64'h1);
      check("b2b_first_p_held", 64'(pb), 64'h0);
      prev_p = 48'h9000_0000_0000;
      @(posedge clk); #1;

      // start pulse during CALC must be ignored
      start_op(24'hC00000, 24'hA00000, 1'b0, 1'b1);
      repeat (4) begin @(posedge clk); #1; end
      a = 24'hFFFFFF; b = 24'hFFFFFF; sa = 1'b1; sb = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(prev_p, n, rb, pb);
      check("ign_latency", 64'(n + 5), 64'(exp_edges(24'hA00000)));
      check("ign_p", 64'(p), 64'h7800_0000_0000);
      check("ign_sign", 64'(sign_out), 64'h1);
      prev_p = 48'h7800_0000_0000;
      @(posedge clk); #1;

      // asynchronous reset in CALC cycle 10
      start_op(24'hFFFFFF, 24'hFFFFFF, 1'b1, 1'b0);
      repeat (9) begin @(posedge clk); #1; end
      check("mid_ready_before", 64'(ready), 64'h0);
      rst_n = 1'b0;
      #1;
      check("mid_rst_p", 64'(p), 64'h0);
      check("mid_rst_done", 64'(done), 64'h0);
      check("mid_rst_ready", 64'(ready), 64'h1);
      check("mid_rst_sign", 64'(sign_out), 64'h0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      prev_p = '0;
      start_op(24'hA00000, 24'h800000, 1'b0, 1'b0);
      wait_done(prev_p, n2, rb, pb);
      check("post_rst_latency", 64'(n2), 64'(exp_edges(24'h800000)));
      check("post_rst_p", 64'(p), 64'h5000_0000_0000);
      check("post_rst_p_zero_during", 64'(pb), 64'h0);

      $display("Result: errors=%0d of %0d checks", nerrs, nchecks);
      $finish;
   end

endmodule

// File: doc/mant_mult_seq.md
Name: mant_mult_seq

Overview:
- Iterative radix-2 shift-add multiplier for the 24-bit significands (hidden bit included) of the single-precision FP multiplier.
- Sits directly upstream of the normalisation stage and produces its 48-bit raw product P.
- Also produces the result sign.
- Trades latency for area: one add/shift per cycle, with a start/done handshake to the FP-multiplier control.

Parameters:
- MANT_W, 24, significand width including hidden bit.
- PROD_W, 2*MANT_W (48), product width; derived, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only while ready=1.
- a  input  MANT_W  multiplicand significand.
- b  input  MANT_W  multiplier significand.
- sa  input  1  sign of operand A.
- sb  input  1  sign of operand B.
- ready  output  1  high in IDLE and DONE; start accepted.
- done  output  1  one-cycle pulse: p and sign_out valid.
- p  output  PROD_W  product a*b, unsigned; fed to normaliser P.
- sign_out  output  1  sa^sb, captured at start.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, p=0, sign_out=0, done=0, ready=1, count=0. Applies immediately, including mid-CALC; the partial result is discarded.
- Internal product register R is MANT_W*2+1 bits: {carry, hi[MANT_W-1:0], lo[MANT_W-1:0]}. A_reg holds a.
- States:
  - IDLE: on start, load A_reg=a, hi=0, carry=0, lo=b, sign_out=sa^sb, count=0; go to CALC.
  - CALC: each cycle, if lo[0] then {carry,hi} = hi + A_reg (MANT_W+1-bit add), else unchanged. Then R is shifted right by 1 (logical), and count increments. When count reaches MANT_W-1 in this cycle (the 24th CALC cycle), go to DONE. start is ignored in CALC.
  - DONE: done=1 for exactly this cycle. p = R[PROD_W-1:0], registered on the CALC->DONE transition and held until the next start is accepted. Without start, go to IDLE. With start, load new operands as from IDLE and go to CALC; back-to-back throughput is 1 op per 25 cycles.
- Latency: start accepted at edge k gives CALC cycles k+1..k+24 and done high in cycle k+25.
- p is stable from done until the next accepted start. In IDLE after DONE, p retains the last value. p updates only at the CALC->DONE transition.
- Arithmetic: the carry bit never propagates beyond R. The final p equals the exact unsigned a*b, so no overflow is possible.
- Zero operands need no special case: they produce p=0 through the normal path.
- Signs do not affect p.

Optional Feature:
- Macro: MANT_MULT_EARLY_TERM_EN.
- Defined:
  - In each CALC cycle, first evaluate whether the unprocessed multiplier bits (lo[MANT_W-1-count:0]) are all zero.
  - If they are, R is shifted right by (MANT_W-count) in that single cycle, with no add, and the state goes to DONE.
  - Latency becomes data-dependent: minimum 2 cycles (b=0), maximum 25 cycles.
  - Result is identical to the base design.
- Undefined: fixed 25-cycle latency; no zero detect or barrel shift is synthesised.

Decomposition:
- Package fp_mult_pkg holds:
  - MANT_W and PROD_W localparams.
  - Exponent BIAS = 127.
  - typedef enum logic [1:0] {IDLE, CALC, DONE} mult_state_t.
  - typedef logic [PROD_W-1:0] prod_t.
- No sub-module: the adder and shifter are inline; the counter is 5 bits.

Test Plan:
- 1.0 x 1.0: a=b=24'h800000, sa=0, sb=1, start -> done at start+25; p=48'h4000_0000_0000 (P[47]=0); sign_out=1; ready=0 during CALC.
- Max operands: a=b=24'hFFFFFF -> p=48'hFFFF_FE00_0001 (P[47]=1); done exactly one cycle wide.
- Back-to-back: assert start in the DONE cycle with a=24'hC00000 (1.5), b=24'hC00000 -> second done 25 cycles later; p=48'h9000_0000_0000; first p held until second done.
- Reset mid-op: start, drop rst_n in CALC cycle 10 -> p=0, done=0, ready=1 immediately. Next start with a=24'hA00000, b=24'h800000 -> p=48'h5000_0000_0000 at +25.
- start ignored in CALC: pulse start with different operands at CALC cycle 5 -> result and latency unchanged.
- Early termination (MANT_MULT_EARLY_TERM_EN defined):
  - a=24'h800000, b=24'h000003 -> done at start+4; p=48'h0000_0180_0000.
  - b=0 -> done at start+2; p=0.
  - Without the macro, the same stimulus gives done at start+25 with identical p.
